// File: rtl/lzrw1_group_packer_if.sv
// Valid/ready item input and byte-stream output of the LZRW1 group packer.
// slave is the packer side, master is the surrounding source/sink.
interface lzrw1_group_packer_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_is_copy;
    logic [7:0]  in_literal;
    logic [11:0] in_offset;
    logic [3:0]  in_length;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_last;

    modport slave (
        input  in_valid, in_is_copy, in_literal, in_offset, in_length, in_last,
        output in_ready,
        output out_valid, out_byte, out_last,
        input  out_ready
    );

    modport master (
        output in_valid, in_is_copy, in_literal, in_offset, in_length, in_last,
        input  in_ready,
        input  out_valid, out_byte, out_last,
        output out_ready
    );
endinterface

// File: rtl/lzrw1_group_packer.sv
// LZRW1 group packer: collects up to 16 literal/copy items, then streams
// the 16-bit control word (low byte first) followed by the item bytes.
module lzrw1_group_packer #(
    parameter int GROUPSIZE = 16,
    parameter int OFFSETW   = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    lzrw1_group_packer_if.slave   bus,
    output logic                  busy
);

    typedef enum logic [1:0] {FILL, CW_LO, CW_HI, ITEMS} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  item_cnt;
    logic [15:0] ctrl;
    logic [3:0]  emit_idx;
    logic        byte_sel;
    logic        last_flag;
    logic [7:0]  byte0 [GROUPSIZE];
    logic [7:0]  byte1 [GROUPSIZE];

    logic accept;
    logic slot_copy;
    logic slot_end;
    logic slot_last;

    // A copy slot takes two bytes; its item ends only on the second one.
    assign slot_copy = ctrl[emit_idx];
    assign slot_end  = !slot_copy || byte_sel;
    assign slot_last = ({1'b0, emit_idx} + 5'd1) == item_cnt;
    assign busy      = (state != FILL) || (item_cnt != 5'd0);

    // Next-state and handshake/output decode; outputs depend on state only
    // so they hold steady while the sink stalls.
    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_byte  = 8'h00;
        bus.out_last  = 1'b0;
        unique case (state)
            FILL: begin
                bus.in_ready = 1'b1;
                accept       = bus.in_valid;
                if (accept &&
                    (item_cnt == 5'(GROUPSIZE - 1) || bus.in_last))
                    state_nxt = CW_LO;
            end
            CW_LO: begin
                bus.out_valid = 1'b1;
                bus.out_byte  = ctrl[7:0];
                if (bus.out_ready) state_nxt = CW_HI;
            end
            CW_HI: begin
                bus.out_valid = 1'b1;
                bus.out_byte  = ctrl[15:8];
                if (bus.out_ready) state_nxt = ITEMS;
            end
            ITEMS: begin
                bus.out_valid = 1'b1;
                bus.out_byte  = byte_sel ? byte1[emit_idx] : byte0[emit_idx];
                bus.out_last  = last_flag && slot_end && slot_last;
                if (bus.out_ready && slot_end && slot_last)
                    state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= FILL;
        else        state <= state_nxt;
    end

    // Group bookkeeping: fill counter, control word, emit cursor, last flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            item_cnt  <= 5'd0;
            ctrl      <= 16'h0000;
            emit_idx  <= 4'd0;
            byte_sel  <= 1'b0;
            last_flag <= 1'b0;
        end else begin
            if (accept) begin
                ctrl[item_cnt[3:0]] <= bus.in_is_copy;
                item_cnt            <= item_cnt + 5'd1;
                last_flag           <= bus.in_last;
            end
            if (state == CW_HI && bus.out_ready) begin
                emit_idx <= 4'd0;
                byte_sel <= 1'b0;
            end
            if (state == ITEMS && bus.out_ready) begin
                if (!slot_end) begin
                    byte_sel <= 1'b1;
                end else if (slot_last) begin
                    item_cnt  <= 5'd0;
                    ctrl      <= 16'h0000;
                    emit_idx  <= 4'd0;
                    byte_sel  <= 1'b0;
                    last_flag <= 1'b0;
                end else begin
                    emit_idx <= emit_idx + 4'd1;
                    byte_sel <= 1'b0;
                end
            end
        end
    end

    // Item storage; contents are only meaningful below item_cnt.
    always_ff @(posedge clock) begin
        if (accept) begin
            if (bus.in_is_copy) begin
                byte0[item_cnt[3:0]] <= {bus.in_offset[OFFSETW-1:8],
                                         bus.in_length};
                byte1[item_cnt[3:0]] <= bus.in_offset[7:0];
            end else begin
                byte0[item_cnt[3:0]] <= bus.in_literal;
                byte1[item_cnt[3:0]] <= 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_lzrw1_group_packer.sv
// Directed bench for lzrw1_group_packer: single-item table plus
// multi-item, backpressure, two-group and reset-abort sequences.
module tb_lzrw1_group_packer;

    logic clock = 1'b0;
    logic reset;
    logic busy;
    int   checks = 0;
    int   failures = 0;
    logic [7:0] exp_q[$];

    lzrw1_group_packer_if bus ();

    lzrw1_group_packer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave),
        .busy  (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        is_copy;
        logic [7:0]  lit;
        logic [11:0] off;
        logic [3:0]  len;
        int          nbytes;
        logic [31:0] bytes;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_item(input logic is_copy, input logic [7:0] lit,
                             input logic [11:0] off, input logic [3:0] len,
                             input logic last);
        int n = 0;
        bus.in_valid   = 1'b1;
        bus.in_is_copy = is_copy;
        bus.in_literal = lit;
        bus.in_offset  = off;
        bus.in_length  = len;
        bus.in_last    = last;
        while (!bus.in_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!bus.in_ready) check("send_timeout", 0, 1);
        @(posedge clock);
        @(negedge clock);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic collect(input bit toggle, input bit last_grp);
        int   got = 0;
        int   cyc = 0;
        bit   stalled = 0;
        logic [7:0] held = 8'h00;
        check("latency", {31'd0, bus.out_valid}, 1);
        while (got < exp_q.size() && cyc < 300) begin
            bus.out_ready = toggle ? ~cyc[0] : 1'b1;
            #1;
            if (bus.out_valid) begin
                check("in_ready_emit", {31'd0, bus.in_ready}, 0);
                if (stalled) check("hold", {24'd0, bus.out_byte}, {24'd0, held});
                if (bus.out_ready) begin
                    check($sformatf("byte%0d", got),
                          {24'd0, bus.out_byte}, {24'd0, exp_q[got]});
                    check($sformatf("last%0d", got), {31'd0, bus.out_last},
                          {31'd0, last_grp && (got == exp_q.size() - 1)});
                    got++;
                    stalled = 0;
                end else begin
                    held    = bus.out_byte;
                    stalled = 1;
                end
            end
            @(posedge clock);
            @(negedge clock);
            cyc++;
        end
        if (got < exp_q.size()) check("collect_timeout", got, exp_q.size());
        bus.out_ready = 1'b1;
        check("idle_valid", {31'd0, bus.out_valid}, 0);
        check("idle_ready", {31'd0, bus.in_ready}, 1);
    endtask

    initial begin
        reset          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_is_copy = 1'b0;
        bus.in_literal = 8'h00;
        bus.in_offset  = 12'h000;
        bus.in_length  = 4'h0;
        bus.in_last    = 1'b0;
        bus.out_ready  = 1'b1;

        vecs[0] = '{1'b0, 8'h00, 12'h000, 4'h0, 3, 32'h0000_0000};
        vecs[1] = '{1'b0, 8'hFF, 12'h000, 4'h0, 3, 32'h0000_FF00};
        vecs[2] = '{1'b1, 8'h00, 12'hFFF, 4'hF, 4, 32'h0100_FFFF};
        vecs[3] = '{1'b1, 8'h00, 12'h001, 4'h0, 4, 32'h0100_0001};
        vecs[4] = '{1'b1, 8'h00, 12'h800, 4'h3, 4, 32'h0100_8300};

        @(negedge clock);
        check("rst_out_valid", {31'd0, bus.out_valid}, 0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 1);
        check("rst_out_byte", {24'd0, bus.out_byte}, 0);
        check("rst_out_last", {31'd0, bus.out_last}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        reset = 1'b1;
        @(negedge clock);

        // Single-item groups from the table.
        for (int v = 0; v < 5; v++) begin
            exp_q.delete();
            for (int b = 0; b < vecs[v].nbytes; b++)
                exp_q.push_back(vecs[v].bytes[31 - 8*b -: 8]);
            send_item(vecs[v].is_copy, vecs[v].lit, vecs[v].off,
                      vecs[v].len, 1'b1);
            collect(1'b0, 1'b1);
        end

        // 16 literals 0x41..0x50.
        exp_q.delete();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(8'h41 + i));
            send_item(1'b0, 8'(8'h41 + i), 12'h000, 4'h0, i == 15);
        end
        collect(1'b0, 1'b1);

        // 16 copies offset 0xABC length 5.
        exp_q.delete();
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'hA5);
            exp_q.push_back(8'hBC);
            send_item(1'b1, 8'h00, 12'hABC, 4'h5, i == 15);
        end
        collect(1'b0, 1'b1);

        // Mixed 3-item group, then the same under backpressure.
        for (int t = 0; t < 2; t++) begin
            exp_q = '{8'h02, 8'h00, 8'h11, 8'h17, 8'h23, 8'h22};
            send_item(1'b0, 8'h11, 12'h000, 4'h0, 1'b0);
            check("busy_fill", {31'd0, busy}, 1);
            send_item(1'b1, 8'h00, 12'h123, 4'h7, 1'b0);
            send_item(1'b0, 8'h22, 12'h000, 4'h0, 1'b1);
            collect(t == 1, 1'b1);
        end

        // 17 literals: full group without last, then a 1-item last group.
        exp_q.delete();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(i + 1));
            send_item(1'b0, 8'(i + 1), 12'h000, 4'h0, 1'b0);
        end
        collect(1'b0, 1'b0);
        exp_q = '{8'h00, 8'h00, 8'h11};
        send_item(1'b0, 8'h11, 12'h000, 4'h0, 1'b1);
        collect(1'b0, 1'b1);

        // Reset while the high control byte is on the bus.
        send_item(1'b0, 8'h55, 12'h000, 4'h0, 1'b1);
        @(posedge clock);
        @(negedge clock);
        check("pre_rst_cw_hi", {31'd0, bus.out_valid}, 1);
        #2 reset = 1'b0;
        #1;
        check("abort_out_valid", {31'd0, bus.out_valid}, 0);
        check("abort_in_ready", {31'd0, bus.in_ready}, 1);
        check("abort_busy", {31'd0, busy}, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("post_rst_idle", {31'd0, bus.out_valid}, 0);
        exp_q = '{8'h00, 8'h00, 8'h7E};
        send_item(1'b0, 8'h7E, 12'h000, 4'h0, 1'b1);
        collect(1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lzrw1_group_packer.md
Name: lzrw1_group_packer

Overview:
- Downstream stage of the compressor core; consumes one compressed item per handshake: a literal byte or a copy (offset, length).
- Groups up to 16 items, builds the 16-bit control word for the group and serializes the group as a byte stream: control word first, then the item bytes.
- Replaces the flat compArray/controlWord arrays with a streaming output for the memory/IO writer.

Parameters:
- GROUPSIZE, 16, items per control word; fixed at 16, because the control word is 16 bits.
- OFFSETW, 12, copy offset width; matches the 4096-entry history.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  item presented.
- in_ready  output  1  packer accepts the item this cycle.
- in_is_copy  input  1  1 = copy item, 0 = literal.
- in_literal  input  8  literal byte; valid when in_is_copy=0.
- in_offset  input  12  copy offset; valid when in_is_copy=1.
- in_length  input  4  copy length code from the comparator; passed through unchanged.
- in_last  input  1  final item of the input string.
- out_valid  output  1  out_byte is valid.
- out_ready  input  1  downstream accepts the byte.
- out_byte  output  8  packed stream byte.
- out_last  output  1  final byte of the final group.
- busy  output  1  the packer is in any state other than FILL, or item_cnt != 0.

Behaviour:
- Reset (reset=0, asynchronous): state=FILL, item_cnt=0, ctrl=0, emit_idx=0, in_ready=1, out_valid=0, out_byte=0, out_last=0, busy=0. Buffer contents are don't-care.
- Item buffer: 16 entries × {is_copy, byte0, byte1}.
  - Literal: byte0 = in_literal; byte1 unused.
  - Copy: byte0 = {in_offset[11:8], in_length}; byte1 = in_offset[7:0].
- ctrl[i] = in_is_copy of item i. Control bits of unfilled slots stay 0.
- FILL:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready: write slot item_cnt, set ctrl bit, item_cnt++. Capture last_flag = in_last.
  - Go to CW_LO on the following cycle when the accepted item makes item_cnt=16 or has in_last=1. Otherwise stay in FILL.
- CW_LO: in_ready=0, out_valid=1, out_byte=ctrl[7:0]. On out_ready, go to CW_HI.
- CW_HI: out_byte=ctrl[15:8]. On out_ready, go to ITEMS with emit_idx=0, byte_sel=0.
- ITEMS:
  - Literal slot: emit byte0, one byte for that item.
  - Copy slot: emit byte0, then byte1.
  - Advance only on out_ready. After the last byte of slot item_cnt-1, go to FILL with item_cnt=0, ctrl=0.
- out_last=1 only on the final byte of ITEMS when last_flag=1. It is 0 for control-word bytes, unless the group is empty, which cannot occur.
- Output hold: while out_valid=1 and out_ready=0, out_byte and out_last are held stable.
- Throughput:
  - Items are not accepted during the emit states; the pipeline is single-buffered.
  - One item per cycle in FILL; one byte per cycle in the emit states when out_ready=1.
- Latency: first control byte appears on out_byte the cycle after the closing item is accepted.
- Group size: a full group emits 2 + (16 + number of copies) bytes, 18 to 34 total. A partial group of N items emits 2 + N + number of copies bytes.
- After a last-group emit, return to FILL ready for a new string. last_flag clears on entry to FILL.
- Reset mid-emit aborts the group immediately. No partial bytes are emitted after reset is released.
- in_valid while in_ready=0 is ignored. The source must hold the item, per standard valid/ready rules.

Test Plan:
- 16 literals 0x41..0x50, in_last on the 16th, out_ready=1 → bytes 0x00, 0x00, 0x41..0x50 (18 bytes), out_last on 0x50, then in_ready=1.
- 16 copies with offset=0xABC, length=0x5 → ctrl bytes 0xFF, 0xFF, then 16× (0xA5, 0xBC), 34 bytes total.
- 3 items L(0x11), C(0x123, 0x7), L(0x22) with in_last → 0x02, 0x00, 0x11, 0x17, 0x23, 0x22, out_last on 0x22.
- Backpressure: same 3-item group with out_ready toggling 1-0-1-0 → identical byte sequence; out_byte stable during every stall; in_ready=0 throughout emit.
- Two groups: 17 literals, in_last on the 17th → group 1 has 18 bytes with out_last=0; group 2 is 0x00, 0x00, literal 17 with out_last=1.
- Assert reset during CW_HI of a group → out_valid=0 and in_ready=1 asynchronously. After release, a single literal 0x7E with in_last emits 0x00, 0x00, 0x7E only.
